// File: rtl/debug_uart_rx.sv
// 8N1 serial receiver that packs six consecutive bytes into one 48-bit word.
// A bad stop bit or an over-long gap between bytes discards the partial word.
module debug_uart_rx #(
   parameter int CLK_FRE      = 33,
   parameter int BAUD_RATE    = 1000000,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        uart_rx,
   output logic [47:0] dataout,
   output logic        data_de,
   output logic        frame_err
);

   localparam int CYCLE   = CLK_FRE * 1000000 / BAUD_RATE;
   localparam int TIMEOUT = TIMEOUT_BITS * CYCLE;
   localparam int CW      = $clog2(CYCLE + 1);
   localparam int TW      = $clog2(TIMEOUT + 1);

   localparam logic [CW-1:0] CNT_MID  = CW'(CYCLE / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CYCLE - 1);
   localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_reg, state_next;
   logic            rx_meta_reg, rx_sync_reg, rx_prev_reg;
   logic [CW-1:0]   cnt_reg;
   logic [2:0]      bit_cnt_reg;
   logic [7:0]      shift_reg;
   logic [39:0]     asm_reg;
   logic [2:0]      index_reg;
   logic [TW-1:0]   idle_cnt_reg;
   logic            idle_run_reg;
   logic            wait_high_reg;

   logic            fall;
   logic            start_ok;
   logic            data_tick;
   logic            stop_ok;
   logic            stop_bad;

   assign fall = rx_prev_reg & ~rx_sync_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_reg <= 1'b1;
         rx_sync_reg <= 1'b1;
         rx_prev_reg <= 1'b1;
         state_reg   <= IDLE;
      end else begin
         rx_meta_reg <= uart_rx;
         rx_sync_reg <= rx_meta_reg;
         rx_prev_reg <= rx_sync_reg;
         state_reg   <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      start_ok   = 1'b0;
      data_tick  = 1'b0;
      stop_ok    = 1'b0;
      stop_bad   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (fall && !wait_high_reg)
               state_next = START;
         end
         START: begin
            if (cnt_reg == CNT_MID) begin
               if (!rx_sync_reg) begin
                  state_next = DATA;
                  start_ok   = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         DATA: begin
            if (cnt_reg == CNT_LAST) begin
               data_tick = 1'b1;
               if (bit_cnt_reg == 3'd7)
                  state_next = STOP;
            end
         end
         STOP: begin
            if (cnt_reg == CNT_LAST) begin
               state_next = IDLE;
               stop_ok    = rx_sync_reg;
               stop_bad   = ~rx_sync_reg;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Bit timing: the counter restarts on every state change and on every data sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg       <= '0;
         bit_cnt_reg   <= 3'd0;
         shift_reg     <= 8'h00;
         wait_high_reg <= 1'b0;
      end else begin
         if (state_reg == IDLE || state_next != state_reg || data_tick)
            cnt_reg <= '0;
         else
            cnt_reg <= cnt_reg + 1'b1;

         if (start_ok)
            bit_cnt_reg <= 3'd0;
         else if (data_tick)
            bit_cnt_reg <= bit_cnt_reg + 3'd1;

         if (data_tick)
            shift_reg <= {rx_sync_reg, shift_reg[7:1]};

         if (stop_bad)
            wait_high_reg <= 1'b1;
         else if (rx_sync_reg)
            wait_high_reg <= 1'b0;
      end
   end

   // Word assembly; a confirmed start takes priority over a gap timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asm_reg      <= 40'h0;
         index_reg    <= 3'd0;
         idle_cnt_reg <= '0;
         idle_run_reg <= 1'b0;
         dataout      <= 48'h0;
         data_de      <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         data_de   <= 1'b0;
         frame_err <= 1'b0;
         if (stop_ok) begin
            asm_reg <= {asm_reg[31:0], shift_reg};
            if (index_reg == 3'd5) begin
               dataout      <= {asm_reg, shift_reg};
               data_de      <= 1'b1;
               index_reg    <= 3'd0;
               idle_run_reg <= 1'b0;
            end else begin
               index_reg    <= index_reg + 3'd1;
               idle_run_reg <= 1'b1;
               idle_cnt_reg <= '0;
            end
         end else if (stop_bad) begin
            index_reg    <= 3'd0;
            frame_err    <= 1'b1;
            idle_run_reg <= 1'b0;
         end else if (start_ok) begin
            idle_run_reg <= 1'b0;
         end else if (idle_run_reg) begin
            if (idle_cnt_reg == IDLE_MAX) begin
               index_reg    <= 3'd0;
               idle_run_reg <= 1'b0;
            end else begin
               idle_cnt_reg <= idle_cnt_reg + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_debug_uart_rx.sv
// Directed bench for debug_uart_rx: serial stimulus, expected words queued at send time.
module tb_debug_uart_rx;

   localparam int CYCLE = 33;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        uart_rx = 1'b1;
   logic [47:0] dataout;
   logic        data_de;
   logic        frame_err;

   int checks = 0;
   int errors = 0;

   logic [47:0] exp_q[$];
   int          fe_exp = 0;

   logic [47:0] got_mem [256];
   int          got_n = 0;
   int          got_rd = 0;
   int          fe_seen = 0;
   int          both_seen = 0;

   debug_uart_rx #(
      .CLK_FRE(33),
      .BAUD_RATE(1000000),
      .TIMEOUT_BITS(20)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .uart_rx(uart_rx),
      .dataout(dataout),
      .data_de(data_de),
      .frame_err(frame_err)
   );

   always #15 clk = ~clk;

   always @(negedge clk) begin
      if (data_de) begin
         got_mem[got_n[7:0]] <= dataout;
         got_n <= got_n + 1;
         $display("word received %h", dataout);
      end
      if (frame_err) begin
         fe_seen <= fe_seen + 1;
         $display("frame error pulse");
      end
      if (data_de && frame_err)
         both_seen <= both_seen + 1;
   end

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap_bits);
      uart_rx = 1'b0;
      repeat (CYCLE) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CYCLE) @(negedge clk);
      end
      uart_rx = stop_bit;
      repeat (CYCLE) @(negedge clk);
      uart_rx = 1'b1;
      repeat (gap_bits * CYCLE) @(negedge clk);
   endtask

   task automatic send_word(input logic [47:0] w, input int gap_bits);
      logic [47:0] t;
      t = w;
      for (int i = 0; i < 6; i++) begin
         send_byte(t[47:40], 1'b1, gap_bits);
         t = t << 8;
      end
      exp_q.push_back(w);
   endtask

   task automatic verify(input string tag);
      logic [47:0] g;
      logic [47:0] e;
      int          want;
      want = exp_q.size();
      for (int k = 0; k < 10 * CYCLE && (got_n - got_rd) < want; k++)
         @(negedge clk);
      repeat (2 * CYCLE) @(negedge clk);
      check({tag, "_count"}, 48'(got_n - got_rd), 48'(want));
      while (got_rd < got_n && exp_q.size() > 0) begin
         g = got_mem[got_rd[7:0]];
         e = exp_q.pop_front();
         got_rd++;
         check({tag, "_word"}, g, e);
         $display("%s compared word %h against %h", tag, g, e);
      end
      got_rd = got_n;
      exp_q.delete();
      check({tag, "_ferr"}, 48'(fe_seen), 48'(fe_exp));
      check({tag, "_overlap"}, 48'(both_seen), 48'd0);
      check({tag, "_hold"}, dataout, (want > 0) ? e : dataout);
   endtask

   initial begin
      #5 rst_n = 1'b0;
      #1;
      check("reset_dataout", dataout, 48'h0);
      check("reset_de", 48'(data_de), 48'd0);
      check("reset_ferr", 48'(frame_err), 48'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * CYCLE) @(negedge clk);

      // Six bytes back-to-back.
      send_word(48'h123456789ABC, 0);
      verify("b2b");

      // Short low glitch in the middle of a word is ignored.
      send_byte(8'hC0, 1'b1, 1);
      send_byte(8'hC1, 1'b1, 1);
      send_byte(8'hC2, 1'b1, 1);
      uart_rx = 1'b0;
      repeat (10) @(negedge clk);
      uart_rx = 1'b1;
      repeat (2 * CYCLE) @(negedge clk);
      send_byte(8'hC3, 1'b1, 1);
      send_byte(8'hC4, 1'b1, 1);
      send_byte(8'hC5, 1'b1, 1);
      exp_q.push_back(48'hC0C1C2C3C4C5);
      verify("glitch");

      // Bad stop bit discards the partial word.
      send_byte(8'h11, 1'b1, 0);
      send_byte(8'h22, 1'b1, 0);
      send_byte(8'h33, 1'b0, 1);
      fe_exp++;
      send_word(48'hAABBCCDDEEFF, 0);
      verify("ferr");

      // Long idle gap drops the partial word.
      send_byte(8'h01, 1'b1, 0);
      send_byte(8'h02, 1'b1, 0);
      send_byte(8'h03, 1'b1, 25);
      send_word(48'hA1A2A3A4A5A6, 0);
      verify("timeout");

      // Gap below the timeout keeps the word together.
      send_byte(8'hB1, 1'b1, 0);
      send_byte(8'hB2, 1'b1, 0);
      send_byte(8'hB3, 1'b1, 17);
      send_byte(8'hB4, 1'b1, 0);
      send_byte(8'hB5, 1'b1, 0);
      send_byte(8'hB6, 1'b1, 2);
      exp_q.push_back(48'hB1B2B3B4B5B6);
      verify("short_gap");

      // Reset during bit 4 of byte 2.
      send_byte(8'h77, 1'b1, 1);
      uart_rx = 1'b0;
      repeat (CYCLE) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         uart_rx = i[0];
         repeat (CYCLE) @(negedge clk);
      end
      uart_rx = 1'b1;
      repeat (CYCLE / 2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_dataout", dataout, 48'h0);
      check("midreset_de", 48'(data_de), 48'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * CYCLE) @(negedge clk);
      send_word(48'h5A5A5A5A5A5A, 1);
      verify("reset");

      // Two words with one-bit gaps.
      send_word(48'h000102030405, 1);
      send_word(48'hFAFBFCFDFEFF, 1);
      verify("two_words");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
